// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, D = A - B, LSB first, one bit per CLKIN.
// A single registered borrow flop carries between bit slices.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for START; the last result is held on D/BOUT/Z
// ST_SHIFT | WIDTH cycles, one difference bit produced per cycle
// ST_DONE  | one-cycle DONE pulse; the new result is valid on D/BOUT/Z
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLKIN,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             Z
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic             r_bw;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_z;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_bw_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor slice on the current LSBs and the borrow flop
  always_comb begin
    w_a        = r_sa[0];
    w_b        = r_sb[0];
    w_d        = w_a ^ w_b ^ r_bw;
    w_bw_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_bw);
    w_res_next = {w_d, r_res[WIDTH-1:1]};
    w_last     = (r_state == ST_SHIFT) && (r_count == LAST);
  end

  // State register
  always_ff @(posedge CLKIN) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (START) w_state_next = ST_SHIFT;
      ST_SHIFT: if (r_count == LAST) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture, shifting, borrow flop and bit counter
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_bw    <= 1'b0;
      r_count <= '0;
    end else if (r_state == ST_IDLE && START) begin
      r_sa    <= A;
      r_sb    <= B;
      r_res   <= '0;
      r_bw    <= 1'b0;
      r_count <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
      r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
      r_res   <= w_res_next;
      r_bw    <= w_bw_next;
      r_count <= r_count + 1'b1;
    end
  end

  // Result registers load on the final slice so they are valid during DONE
  // and never show a partial difference
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      r_d    <= '0;
      r_bout <= 1'b0;
      r_z    <= 1'b1;
    end else if (w_last) begin
      r_d    <= w_res_next;
      r_bout <= w_bw_next;
      r_z    <= (w_res_next == '0);
    end
  end

  // Status outputs decode the state register only
  always_comb begin
    BUSY = (r_state != ST_IDLE);
    DONE = (r_state == ST_DONE);
    D    = r_d;
    BOUT = r_bout;
    Z    = r_z;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLKIN = 1'b0;
  logic         RESET;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] D;
  logic         BOUT;
  logic         Z;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] prev_d;
  logic         prev_bout;
  logic         prev_z;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLKIN(CLKIN), .RESET(RESET), .START(START), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .D(D), .BOUT(BOUT), .Z(Z)
  );

  always #5 CLKIN = ~CLKIN;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKIN);
    #1;
  endtask

  // One operation from IDLE: checks latency, BUSY width, hold and result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ed, input logic eb, input logic ez);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge CLKIN);
    A = a; B = b; START = 1'b1;
    tick();
    START = 1'b0;
    A = W'($urandom); B = W'($urandom);
    busy_cnt = BUSY ? 1 : 0;
    chk("busy_after_accept", BUSY, 1);
    n = 0;
    seen = 0;
    while (n < 20 && !seen) begin
      tick();
      n++;
      A = W'($urandom); B = W'($urandom);
      if (BUSY) busy_cnt++;
      if (DONE) seen = 1;
      else begin
        chk("hold_d", D, prev_d);
        chk("hold_bout", BOUT, prev_bout);
        chk("hold_z", Z, prev_z);
      end
    end
    chk("done_seen", seen, 1);
    chk("done_latency", n, W);
    chk("busy_cycles", busy_cnt, W + 1);
    chk("d", D, ed);
    chk("bout", BOUT, eb);
    chk("z", Z, ez);
    tick();
    chk("done_pulse_len", DONE, 0);
    chk("busy_after_done", BUSY, 0);
    chk("hold_d_idle", D, ed);
    prev_d = ed; prev_bout = eb; prev_z = ez;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } vec_t;

  vec_t vecs[6] = '{
    '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0},
    '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0},
    '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0},
    '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1},
    '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0},
    '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0}
  };

  function automatic logic [W-1:0] ha(input int c);
    return W'(c * 17 + 3);
  endfunction

  function automatic logic [W-1:0] hb(input int c);
    return W'(c * 29 + 1);
  endfunction

  initial begin
    logic [W-1:0] ra, rb, ed;
    bit           any_done;
    RESET = 1'b1; START = 1'b0; A = '0; B = '0;
    tick(); tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_d", D, 0);
    chk("rst_bout", BOUT, 0);
    chk("rst_z", Z, 1);
    @(negedge CLKIN);
    RESET = 1'b0;
    prev_d = '0; prev_bout = 1'b0; prev_z = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].z);

    // START held high with A/B changing every cycle: accepts at edges 0,10,20
    for (int c = 0; c < 30; c++) begin
      @(negedge CLKIN);
      START = 1'b1; A = ha(c); B = hb(c);
      tick();
      chk("hs_done_slot", DONE, (c % 10) == 8);
      if ((c % 10) == 8) begin
        ed = ha(c - 8) - hb(c - 8);
        chk("hs_d", D, ed);
        chk("hs_bout", BOUT, ha(c - 8) < hb(c - 8));
      end
    end
    @(negedge CLKIN);
    START = 1'b0;
    ed = ha(20) - hb(20);
    prev_d = ed; prev_bout = ha(20) < hb(20); prev_z = (ed == 0);
    tick();
    chk("hs_idle", BUSY, 0);

    // Reset during SHIFT with count=4
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    @(negedge CLKIN);
    A = 8'h40; B = 8'h11; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    @(negedge CLKIN);
    RESET = 1'b1;
    tick();
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_done", DONE, 0);
    chk("mid_rst_d", D, 0);
    chk("mid_rst_bout", BOUT, 0);
    chk("mid_rst_z", Z, 1);
    @(negedge CLKIN);
    RESET = 1'b0;
    any_done = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (DONE) any_done = 1;
    end
    chk("mid_rst_no_done", any_done, 0);
    prev_d = '0; prev_bout = 1'b0; prev_z = 1'b1;
    run_op(8'h40, 8'h11, 8'h2F, 1'b0, 1'b0);

    // Random pairs against a reference model
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 50 == 0) rb = ra;
      ed = ra - rb;
      run_op(ra, rb, ed, ra < rb, ed == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
